// File: rtl/sm_trace_buf_pkg.sv
// Shared trace-entry layout, capture/frozen state encoding and small helpers
// for the retired-instruction trace buffer.
package sm_trace_buf_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int A0_W    = 32;
  localparam int CYC_W   = 16;
  localparam int ENTRY_W = CYC_W + A0_W + INSTR_W + PC_W;

  // Packing order {cycle, a0, instr, pc}, 112 bits
  typedef struct packed {
    logic [CYC_W-1:0]   cycle;
    logic [A0_W-1:0]    a0;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  typedef enum logic {
    CAPTURE = 1'b0,
    FROZEN  = 1'b1
  } trState_t;

  function automatic logic [CYC_W-1:0] satInc16(input logic [CYC_W-1:0] v);
    return (v == '1) ? v : v + CYC_W'(1);
  endfunction

endpackage

// File: rtl/sm_trace_buf_if.sv
// Drain-side valid/ready port of the trace buffer: head entry fields plus handshake.
interface sm_trace_buf_if;
  import sm_trace_buf_pkg::*;

  logic               outValid;
  logic               outReady;
  logic [PC_W-1:0]    outPc;
  logic [INSTR_W-1:0] outInstr;
  logic [A0_W-1:0]    outA0;
  logic [CYC_W-1:0]   outCycle;

  modport master (output outValid, outPc, outInstr, outA0, outCycle, input outReady);
  modport slave  (input outValid, outPc, outInstr, outA0, outCycle, output outReady);
endinterface

// File: rtl/sm_trace_ram.sv
// DEPTH x 112-bit trace storage: synchronous write, asynchronous read, no reset.
module sm_trace_ram
  import sm_trace_buf_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wAddr,
  input  entry_t        wData,
  input  logic [AW-1:0] rAddr,
  output entry_t        rData
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wAddr] <= wData;
  end

  assign rData = mem[rAddr];

endmodule

// File: rtl/sm_trace_buf.sv
// Ring-FIFO trace of {pc, instr, a0, cycle stamp} per enabled CPU cycle, with watchdog freeze.
// Push-to-head latency 1 cycle; when full, new entries are dropped (oldest kept) and counted.
module sm_trace_buf
  import sm_trace_buf_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 120
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trEn,
  input  logic                  clr,
  input  logic [PC_W-1:0]       pc,
  input  logic [INSTR_W-1:0]    instr,
  input  logic [A0_W-1:0]       a0,
  sm_trace_buf_if.master        drain,
  output logic [$clog2(DEPTH):0] count,
  output logic                  overflow,
  output logic [15:0]           dropCnt,
  output logic                  timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]    FULL_CNT   = CW'(DEPTH);
  localparam logic [CYC_W-1:0] LAST_STAMP = CYC_W'(TIMEOUT - 1);
  localparam bit               WD_EN      = (TIMEOUT != 0);

  trState_t         state, stateNxt;
  logic [AW-1:0]    wrPtr, rdPtr;
  logic [CYC_W-1:0] cycle;
  logic             capture, pop, full, drop, store, fire;
  entry_t           wEntry, head;

  always_comb begin
    capture = (state == CAPTURE) && trEn;
    pop     = (count != '0) && drain.outReady;
    full    = (count == FULL_CNT);
    drop    = capture && full && !pop;
    store   = capture && !drop;
    fire    = WD_EN && capture && (cycle == LAST_STAMP);
    wEntry  = '{cycle: cycle, a0: a0, instr: instr, pc: pc};
  end

  sm_trace_ram #(.DEPTH(DEPTH)) uRam (
    .clk   (clk),
    .we    (store && !clr),
    .wAddr (wrPtr),
    .wData (wEntry),
    .rAddr (rdPtr),
    .rData (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CAPTURE;
    else        state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      CAPTURE: if (fire) stateNxt = FROZEN;
      FROZEN:  stateNxt = FROZEN;
      default: stateNxt = CAPTURE;
    endcase
    if (clr) stateNxt = CAPTURE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      cycle    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      dropCnt  <= '0;
    end else if (clr) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      cycle    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      dropCnt  <= '0;
    end else begin
      if (store)   wrPtr <= wrPtr + AW'(1);
      if (pop)     rdPtr <= rdPtr + AW'(1);
      if (capture) cycle <= cycle + CYC_W'(1);
      count <= count + CW'(store) - CW'(pop);
      if (drop) begin
        overflow <= 1'b1;
        dropCnt  <= satInc16(dropCnt);
      end
    end
  end

  // Storage has no reset, so data outputs are gated to read zero while empty
  assign drain.outValid = (count != '0);
  assign drain.outPc    = drain.outValid ? head.pc    : '0;
  assign drain.outInstr = drain.outValid ? head.instr : '0;
  assign drain.outA0    = drain.outValid ? head.a0    : '0;
  assign drain.outCycle = drain.outValid ? head.cycle : '0;
  assign timeout        = (state == FROZEN);

endmodule

// File: tb/tb_sm_trace_buf.sv
// Three trace buffers (16/120, 16/8, 4/disabled) driven in lockstep and checked
// against a queue-based model of the trace rules, plus directed spot checks.
module tb_sm_trace_buf;

  typedef struct packed {
    logic [15:0] cyc;
    logic [31:0] a0;
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  localparam int DEP [3] = '{16, 16, 4};
  localparam int TOV [3] = '{120, 8, 0};
  string nm [3] = '{"A", "B", "C"};

  logic clk, rst_n, trEn, clr, rdy;
  logic [31:0] pc, instr, a0;
  logic [4:0]  cntA, cntB;
  logic [2:0]  cntC;
  logic        ovfA, ovfB, ovfC, toA, toB, toC;
  logic [15:0] dcA, dcB, dcC;

  sm_trace_buf_if ifA ();
  sm_trace_buf_if ifB ();
  sm_trace_buf_if ifC ();
  assign ifA.outReady = rdy;
  assign ifB.outReady = rdy;
  assign ifC.outReady = rdy;

  sm_trace_buf #(.DEPTH(16), .TIMEOUT(120)) dutA (
    .clk(clk), .rst_n(rst_n), .trEn(trEn), .clr(clr), .pc(pc), .instr(instr), .a0(a0),
    .drain(ifA.master), .count(cntA), .overflow(ovfA), .dropCnt(dcA), .timeout(toA));
  sm_trace_buf #(.DEPTH(16), .TIMEOUT(8)) dutB (
    .clk(clk), .rst_n(rst_n), .trEn(trEn), .clr(clr), .pc(pc), .instr(instr), .a0(a0),
    .drain(ifB.master), .count(cntB), .overflow(ovfB), .dropCnt(dcB), .timeout(toB));
  sm_trace_buf #(.DEPTH(4), .TIMEOUT(0)) dutC (
    .clk(clk), .rst_n(rst_n), .trEn(trEn), .clr(clr), .pc(pc), .instr(instr), .a0(a0),
    .drain(ifC.master), .count(cntC), .overflow(ovfC), .dropCnt(dcC), .timeout(toC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   nAssert = 0;
  int   nFail   = 0;
  ent_t mq [3][$];
  int   mCyc [3];
  bit   mFrz [3];
  bit   mOvf [3];
  int   mDrop [3];
  bit   recB = 0;
  logic [15:0] bStamps [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mReset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      mCyc[i] = 0; mFrz[i] = 0; mOvf[i] = 0; mDrop[i] = 0;
    end
  endtask

  // One clock edge of the trace rules, applied to the inputs currently driven
  task automatic mEdge();
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        mq[i].delete();
        mCyc[i] = 0; mFrz[i] = 0; mOvf[i] = 0; mDrop[i] = 0;
      end else begin
        bit wasFull = (mq[i].size() == DEP[i]);
        bit doPop   = (mq[i].size() != 0) && rdy;
        if (doPop) void'(mq[i].pop_front());
        if (trEn && !mFrz[i]) begin
          if (wasFull && !doPop) begin
            mOvf[i] = 1;
            if (mDrop[i] < 65535) mDrop[i]++;
          end else begin
            mq[i].push_back('{cyc: 16'(mCyc[i]), a0: a0, instr: instr, pc: pc});
          end
          if (TOV[i] != 0 && mCyc[i] == TOV[i] - 1) mFrz[i] = 1;
          mCyc[i] = (mCyc[i] + 1) % 65536;
        end
      end
    end
  endtask

  task automatic checkInst(input int i, input logic v, input logic [31:0] p, input logic [31:0] ins,
                           input logic [31:0] a, input logic [15:0] cy, input logic [31:0] cnt,
                           input logic ov, input logic [15:0] dc, input logic to);
    ent_t h = '0;
    bit   ev = (mq[i].size() != 0);
    if (ev) h = mq[i][0];
    chk($sformatf("%s.outValid", nm[i]), 32'(v), 32'(ev));
    chk($sformatf("%s.outPc", nm[i]), p, h.pc);
    chk($sformatf("%s.outInstr", nm[i]), ins, h.instr);
    chk($sformatf("%s.outA0", nm[i]), a, h.a0);
    chk($sformatf("%s.outCycle", nm[i]), 32'(cy), 32'(h.cyc));
    chk($sformatf("%s.count", nm[i]), cnt, 32'(mq[i].size()));
    chk($sformatf("%s.overflow", nm[i]), 32'(ov), 32'(mOvf[i]));
    chk($sformatf("%s.dropCnt", nm[i]), 32'(dc), 32'(mDrop[i]));
    chk($sformatf("%s.timeout", nm[i]), 32'(to), 32'(mFrz[i]));
  endtask

  task automatic checkAll();
    checkInst(0, ifA.outValid, ifA.outPc, ifA.outInstr, ifA.outA0, ifA.outCycle, 32'(cntA), ovfA, dcA, toA);
    checkInst(1, ifB.outValid, ifB.outPc, ifB.outInstr, ifB.outA0, ifB.outCycle, 32'(cntB), ovfB, dcB, toB);
    checkInst(2, ifC.outValid, ifC.outPc, ifC.outInstr, ifC.outA0, ifC.outCycle, 32'(cntC), ovfC, dcC, toC);
  endtask

  task automatic step();
    if (recB && ifB.outValid && rdy) bStamps.push_back(ifB.outCycle);
    mEdge();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic randData();
    pc = $urandom; instr = $urandom; a0 = $urandom;
  endtask

  initial begin
    int rdyPct;
    rst_n = 1'b1; trEn = 1'b0; clr = 1'b0; rdy = 1'b0;
    pc = '0; instr = '0; a0 = '0;
    mReset();
    #1 rst_n = 1'b0;
    #1;
    chk("reset.outValid", 32'(ifA.outValid), 32'd0);
    chk("reset.count", 32'(cntA), 32'd0);
    checkAll();
    #10 rst_n = 1'b1;

    // Single push then one pop
    trEn = 1'b1; pc = 32'h0; instr = 32'h0050_0513; a0 = 32'h0;
    step();
    chk("single.outValid", 32'(ifA.outValid), 32'd1);
    chk("single.outPc", ifA.outPc, 32'h0);
    chk("single.outInstr", ifA.outInstr, 32'h0050_0513);
    chk("single.outCycle", 32'(ifA.outCycle), 32'd0);
    chk("single.count", 32'(cntA), 32'd1);
    trEn = 1'b0; rdy = 1'b1;
    step();
    chk("single.popCount", 32'(cntA), 32'd0);

    // Fill past capacity, then push and pop together while full
    rdy = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0; trEn = 1'b1;
    for (int k = 0; k < 20; k++) begin randData(); step(); end
    chk("fill.count", 32'(cntA), 32'd16);
    chk("fill.overflow", 32'(ovfA), 32'd1);
    chk("fill.dropCnt", 32'(dcA), 32'd4);
    chk("fill.C.dropCnt", 32'(dcC), 32'd16);
    rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin randData(); step(); end
    chk("fullpp.count", 32'(cntA), 32'd16);
    chk("fullpp.dropCnt", 32'(dcA), 32'd4);
    chk("fullpp.headStamp", 32'(ifA.outCycle), 32'd5);
    trEn = 1'b0;
    for (int k = 0; k < 17; k++) step();
    chk("drain.count", 32'(cntA), 32'd0);

    // Watchdog on B with continuous drain
    clr = 1'b1;
    step();
    clr = 1'b0; trEn = 1'b1; rdy = 1'b1; recB = 1;
    for (int k = 0; k < 12; k++) begin
      randData(); step();
      if (k == 6) chk("wd.timeoutEarly", 32'(toB), 32'd0);
      if (k == 7) chk("wd.timeout8", 32'(toB), 32'd1);
    end
    trEn = 1'b0;
    for (int k = 0; k < 3; k++) step();
    recB = 0;
    chk("wd.entries", 32'(bStamps.size()), 32'd8);
    for (int k = 0; k < bStamps.size(); k++) chk($sformatf("wd.stamp%0d", k), 32'(bStamps[k]), k);
    clr = 1'b1; rdy = 1'b0;
    step();
    clr = 1'b0; trEn = 1'b1; randData();
    step();
    chk("wd.restartStamp", 32'(ifB.outCycle), 32'd0);
    chk("wd.restartTimeout", 32'(toB), 32'd0);

    // Wrap-around on the 4-deep instance
    clr = 1'b1; trEn = 1'b0;
    step();
    clr = 1'b0; trEn = 1'b1; rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      randData(); step();
      chk("wrap.countLe1", 32'(cntC <= 3'd1), 32'd1);
    end
    chk("wrap.overflow", 32'(ovfC), 32'd0);

    // Randomized traffic with occasional clears
    rdyPct = 50;
    for (int k = 0; k < 600; k++) begin
      if (k % 60 == 0) rdyPct = $urandom_range(10, 90);
      trEn = ($urandom_range(0, 3) != 0);
      rdy  = ($urandom_range(1, 100) <= rdyPct);
      clr  = ($urandom_range(0, 79) == 0);
      randData();
      step();
    end

    // Asynchronous reset in the middle of a drain
    clr = 1'b1; trEn = 1'b0; rdy = 1'b0;
    step();
    clr = 1'b0; trEn = 1'b1;
    for (int k = 0; k < 3; k++) begin randData(); step(); end
    trEn = 1'b0; rdy = 1'b1;
    step();
    rdy = 1'b0;
    step();
    rdy = 1'b1;
    #2 rst_n = 1'b0;
    mReset();
    #1;
    chk("arst.outValid", 32'(ifA.outValid), 32'd0);
    chk("arst.count", 32'(cntA), 32'd0);
    chk("arst.flags", 32'({ovfA, toA, dcA}), 32'd0);
    checkAll();
    #2 rst_n = 1'b1;
    rdy = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
